// File: rtl/adder_pipelined.sv
// Pipelined WIDTH-bit adder: one CHUNK-wide slice per stage, carry registered between slices.
// Global-stall valid/ready pipeline with per-transaction signed/unsigned overflow rule.
module adder_pipelined #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CHUNK = WIDTH / STAGES;

  logic w_stall;
  logic w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // operand bits still to be added when entering stage k
    localparam int IW = WIDTH - k * CHUNK;

    logic                   r_vld;
    logic                   r_c;
    logic [(k+1)*CHUNK-1:0] r_sum;

    logic                   w_vin;
    logic                   w_cin;
    logic                   w_sm;
    logic [IW-1:0]          w_a;
    logic [IW-1:0]          w_b;
    logic [CHUNK:0]         w_add;
    logic [(k+1)*CHUNK-1:0] w_sum;

    if (k == 0) begin : g_src
      assign w_vin = in_valid && in_ready;
      assign w_cin = carry_in;
      assign w_sm  = signed_mode;
      assign w_a   = a;
      assign w_b   = b;
      assign w_sum = w_add[CHUNK-1:0];
    end else begin : g_src
      assign w_vin = g_st[k-1].r_vld;
      assign w_cin = g_st[k-1].r_c;
      assign w_sm  = g_st[k-1].g_fwd.r_sm;
      assign w_a   = g_st[k-1].g_fwd.r_a;
      assign w_b   = g_st[k-1].g_fwd.r_b;
      assign w_sum = {w_add[CHUNK-1:0], g_st[k-1].r_sum};
    end

    assign w_add = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_cin};

    // data only moves with a valid token so an empty output keeps its last result
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_c   <= w_add[CHUNK];
          r_sum <= w_sum;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-CHUNK-1:0] r_a;
      logic [IW-CHUNK-1:0] r_b;
      logic                r_sm;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a  <= '0;
          r_b  <= '0;
          r_sm <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_a  <= w_a[IW-1:CHUNK];
          r_b  <= w_b[IW-1:CHUNK];
          r_sm <= w_sm;
        end
      end
    end else begin : g_last
      logic r_ovf;
      logic w_cmsb;

      // carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
      assign w_cmsb = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_add[CHUNK-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_ovf <= w_sm ? (w_cmsb ^ w_add[CHUNK]) : w_add[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].r_vld;
  assign sum       = g_st[STAGES-1].r_sum;
  assign carry_out = g_st[STAGES-1].r_c;
  assign overflow  = g_st[STAGES-1].g_last.r_ovf;

  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = !w_stall && !rst;

endmodule

// File: tb/tb_adder_pipelined.sv
// Scoreboard bench for adder_pipelined: stimulus pushes model results, a negedge monitor
// pops and compares on every presented output, also checking latency, stall hold and reset.
module tb_adder_pipelined;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         signed_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit rand_done = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           icyc;
    int           istall;
  } exp_t;

  exp_t q[$];

  adder_pipelined #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic, signed overflow = true result out of range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sm);
    exp_t   e;
    longint u;
    longint sr;
    longint hi;
    longint lo;
    u  = longint'(x) + longint'(y) + longint'(ci);
    sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    e.s = u[W-1:0];
    e.c = u[W];
    e.o = sm ? ((sr > hi) || (sr < lo)) : u[W];
    e.icyc = 0;
    e.istall = 0;
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin
    bit           head_seen = 0;
    bit           prev_stall = 0;
    bit           prev_rst = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_c = 1'b0;
    logic         prev_o = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready) && !rst});
      if (rst) begin
        q.delete();
        head_seen  = 0;
        prev_stall = 0;
        prev_rst   = 1;
      end else begin
        if (prev_rst) begin
          chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
          chk("rst_sum", {16'd0, sum}, 32'd0);
          chk("rst_carry_out", {31'd0, carry_out}, 32'd0);
          chk("rst_overflow", {31'd0, overflow}, 32'd0);
        end
        if (prev_stall) begin
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_sum", {16'd0, sum}, {16'd0, prev_sum});
          chk("stall_carry_out", {31'd0, carry_out}, {31'd0, prev_c});
          chk("stall_overflow", {31'd0, overflow}, {31'd0, prev_o});
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got sum=%0h with nothing outstanding (cycle %0d)", sum, cyc);
          end else begin
            if (!head_seen) begin
              chk("latency", cyc, q[0].icyc + S + stall_cnt - q[0].istall);
              head_seen = 1;
            end
            chk("sum", {16'd0, sum}, {16'd0, q[0].s});
            chk("carry_out", {31'd0, carry_out}, {31'd0, q[0].c});
            chk("overflow", {31'd0, overflow}, {31'd0, q[0].o});
            if (out_ready) begin
              void'(q.pop_front());
              head_seen = 0;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) stall_cnt++;
        prev_sum = sum;
        prev_c   = carry_out;
        prev_o   = overflow;
        prev_rst = 0;
        if (in_valid && in_ready) begin
          e = model(a, b, carry_in, signed_mode);
          e.icyc   = cyc;
          e.istall = stall_cnt;
          q.push_back(e);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sm);
    int n = 0;
    a = x; b = y; carry_in = ci; signed_mode = sm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
    end
  endtask

  task automatic rnd_issue();
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = W'($urandom());
    y = W'($urandom());
    if ($urandom_range(0, 7) == 0) x = {W{1'b1}};
    if ($urandom_range(0, 7) == 0) y = {1'b0, {(W-1){1'b1}}};
    issue(x, y, 1'(($urandom() & 1)), 1'(($urandom() & 1)));
  endtask

  initial begin
    int n;
    idle(2);
    rst = 1'b0;

    // directed corner cases
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    issue(16'h00FF, 16'h00FF, 1'b1, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b1);
    drain();

    // back-to-back streaming
    for (int i = 0; i < 8; i++) rnd_issue();
    drain();

    // backpressure with three in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rnd_issue();
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    idle(5);
    out_ready = 1'b1;
    drain();

    // reset with three in flight, then a fresh transaction
    for (int i = 0; i < 3; i++) rnd_issue();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    drain();

    // random traffic with random backpressure and bubbles
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          rnd_issue();
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1;
      end
    join
    drain();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
